// File: rtl/ps2_kbd_rx.sv
// ============================================================================
// ps2_kbd_rx -- PS/2 keyboard receiver with a 4-entry scan-code FIFO.
//
// Raw PS/2 clock and data are synchronised, the clock is glitch-filtered,
// and 11-bit frames (start, 8 data LSB-first, odd parity, stop) are
// decoded on filtered falling edges. Good bytes enter a small FIFO; bad
// frames raise one-cycle error pulses.
//
// Ports
//   clock       in   system clock, 25 MHz nominal, rising edge
//   reset_n     in   synchronous active-low reset
//   ps2_clk     in   raw asynchronous PS/2 clock line
//   ps2_data    in   raw asynchronous PS/2 data line
//   rx_data     out  FIFO head byte (0x00 while the FIFO is empty)
//   rx_valid    out  FIFO non-empty
//   rx_ready    in   consumer accepts the head byte
//   parity_err  out  pulse: frame discarded for bad parity
//   frame_err   out  pulse: bad stop bit or timeout abort
//   overflow    out  pulse: good byte dropped, FIFO full
// ============================================================================
module ps2_kbd_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // ---- stage p0/p1: two-flop synchronisers ------------------------------
    logic clk_sync_p0, clk_sync_p1;
    logic data_sync_p0, data_sync_p1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clk_sync_p0  <= 1'b1;
            clk_sync_p1  <= 1'b1;
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
        end else begin
            clk_sync_p0  <= ps2_clk;
            clk_sync_p1  <= clk_sync_p0;
            data_sync_p0 <= ps2_data;
            data_sync_p1 <= data_sync_p0;
        end
    end

    // ---- glitch filter on the synchronised clock --------------------------
    logic              filt_clk;
    logic [FILT_W-1:0] filt_cnt;
    logic              filt_flip;
    logic              fall_edge;
    logic              data_bit;

    // filt_cnt holds how many differing samples preceded this one, so the
    // level flips on the FILTER_LEN-th consecutive differing sample.
    assign filt_flip = (clk_sync_p1 != filt_clk) && (filt_cnt == FILT_LAST);
    assign fall_edge = filt_flip && filt_clk;
    assign data_bit  = data_sync_p1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync_p1 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            filt_clk <= clk_sync_p1;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FILT_W'(1);
        end
    end

    // ---- frame decoder ----------------------------------------------------
    logic [1:0]      state;
    logic [2:0]      bit_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      shift_reg;
    logic            par_bit;
    logic            frame_ok;
    logic            timeout_hit;
    logic            push;

    // Odd parity: the nine bits together must contain an odd number of ones.
    assign frame_ok    = ^{shift_reg, par_bit};
    assign push        = fall_edge && (state == S_STOP) && data_bit && frame_ok;
    assign timeout_hit = (state != S_IDLE) && !fall_edge && (to_cnt == TO_LAST);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            to_cnt     <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (timeout_hit) begin
                state     <= S_IDLE;
                to_cnt    <= '0;
                frame_err <= 1'b1;
            end else begin
                if ((state == S_IDLE) || fall_edge) begin
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
                if (fall_edge) begin
                    case (state)
                        S_IDLE: begin
                            if (!data_bit) begin
                                state   <= S_DATA;
                                bit_cnt <= 3'd0;
                            end
                        end
                        S_DATA: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= S_PARITY;
                            end
                        end
                        S_PARITY: begin
                            state <= S_STOP;
                        end
                        default: begin
                            state <= S_IDLE;
                            if (!data_bit) begin
                                frame_err <= 1'b1;
                            end else if (!frame_ok) begin
                                parity_err <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (fall_edge && (state == S_DATA)) begin
            shift_reg <= {data_bit, shift_reg[7:1]};
        end
        if (fall_edge && (state == S_PARITY)) begin
            par_bit <= data_bit;
        end
    end

    // ---- output FIFO ------------------------------------------------------
    logic [7:0] mem [0:3];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic       full;
    logic       pop;
    logic       wr_en;

    assign full  = (count == 3'd4);
    assign pop   = rx_valid && rx_ready;
    // When full, a simultaneous pop frees the head slot, which is exactly
    // the slot wr_ptr points at, so the write is safe.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full && !pop;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    assign rx_valid = (count != 3'd0);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// ============================================================================
// tb_ps2_kbd_rx -- directed testbench for ps2_kbd_rx.
// The PS/2 clock is scaled (HALF system cycles per phase) and the timeout
// shortened so the whole run stays small.
// ============================================================================
module tb_ps2_kbd_rx;

    localparam int HALF = 50;
    localparam int TMO  = 1000;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int par_cnt = 0;
    int frm_cnt = 0;
    int ovf_cnt = 0;

    ps2_kbd_rx #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #20 clock = ~clock;

    always @(posedge clock) begin
        if (parity_err) par_cnt <= par_cnt + 1;
        if (frame_err)  frm_cnt <= frm_cnt + 1;
        if (overflow)   ovf_cnt <= ovf_cnt + 1;
    end

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par,
                                             input logic stop);
        return {stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    // Device drives data while clock is high, then pulls clock low.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                wait_cycles(20);
                ps2_clk = 1'b0;
                wait_cycles(3);
                ps2_clk = 1'b1;
                wait_cycles(HALF - 23);
            end else begin
                wait_cycles(HALF);
            end
            ps2_clk = 1'b0;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                              input int glitch_bit);
        send_bits(mk_frame(d, bad_par, stop), 11, glitch_bit);
        wait_cycles(HALF);
        ps2_data = 1'b1;
    endtask

    task automatic pop_one();
        @(negedge clock);
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_cycles(4);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if ({parity_err, frame_err, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {parity_err, frame_err, overflow}); end
        reset_n = 1'b1;
        wait_cycles(4);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", rx_valid); end
    endtask

    task automatic test_basic();
        int p, f, o;
        p = par_cnt; f = frm_cnt; o = ovf_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", rx_valid); end
        checks++; if (rx_data !== 8'h1C) begin errors++; $display("FAIL basic_data: got %h want 1c", rx_data); end
        pop_one();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid: got %b want 0", rx_valid); end
        checks++; if ((par_cnt - p) + (frm_cnt - f) + (ovf_cnt - o) !== 0) begin errors++; $display("FAIL basic_flags: got %0d pulses want 0", (par_cnt - p) + (frm_cnt - f) + (ovf_cnt - o)); end
    endtask

    task automatic test_errors();
        int p, f;
        p = par_cnt; f = frm_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        checks++; if (par_cnt - p !== 1) begin errors++; $display("FAIL parity_pulse: got %0d want 1", par_cnt - p); end
        checks++; if (frm_cnt - f !== 0) begin errors++; $display("FAIL parity_no_frame: got %0d want 0", frm_cnt - f); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL parity_valid: got %b want 0", rx_valid); end
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        checks++; if (frm_cnt - f !== 1) begin errors++; $display("FAIL stop_frame_pulse: got %0d want 1", frm_cnt - f); end
        checks++; if (par_cnt - p !== 1) begin errors++; $display("FAIL stop_no_parity: got %0d want 1", par_cnt - p); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL stop_valid: got %b want 0", rx_valid); end
        send_frame(8'h1C, 1'b1, 1'b0, -1);
        checks++; if ((frm_cnt - f !== 2) || (par_cnt - p !== 1)) begin errors++; $display("FAIL err_priority: got frame %0d parity %0d want 2 1", frm_cnt - f, par_cnt - p); end
    endtask

    task automatic test_timeout();
        int f;
        f = frm_cnt;
        send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 5, -1);
        ps2_data = 1'b1;
        wait_cycles(TMO - 150);
        checks++; if (frm_cnt - f !== 0) begin errors++; $display("FAIL timeout_early: got %0d want 0", frm_cnt - f); end
        wait_cycles(250);
        checks++; if (frm_cnt - f !== 1) begin errors++; $display("FAIL timeout_pulse: got %0d want 1", frm_cnt - f); end
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL timeout_next_valid: got %b want 1", rx_valid); end
        checks++; if (rx_data !== 8'hF0) begin errors++; $display("FAIL timeout_next_data: got %h want f0", rx_data); end
        checks++; if (frm_cnt - f !== 1) begin errors++; $display("FAIL timeout_next_flags: got %0d want 1", frm_cnt - f); end
        pop_one();
    endtask

    task automatic test_overflow();
        int o;
        logic [7:0] d;
        o = ovf_cnt;
        rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            d = 8'(k);
            send_frame(d, 1'b0, 1'b1, -1);
            if (k == 4) begin
                checks++; if (ovf_cnt - o !== 0) begin errors++; $display("FAIL ovf_early: got %0d want 0", ovf_cnt - o); end
            end
        end
        checks++; if (ovf_cnt - o !== 1) begin errors++; $display("FAIL ovf_pulse: got %0d want 1", ovf_cnt - o); end
        for (int k = 1; k <= 4; k++) begin
            d = 8'(k);
            checks++; if ((rx_valid !== 1'b1) || (rx_data !== d)) begin errors++; $display("FAIL ovf_drain_%0d: got v=%b %h want v=1 %h", k, rx_valid, rx_data, d); end
            pop_one();
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", rx_valid); end
    endtask

    task automatic test_glitch();
        int p, f;
        p = par_cnt; f = frm_cnt;
        send_frame(8'hAA, 1'b0, 1'b1, 4);
        checks++; if ((rx_valid !== 1'b1) || (rx_data !== 8'hAA)) begin errors++; $display("FAIL glitch_data: got v=%b %h want v=1 aa", rx_valid, rx_data); end
        checks++; if ((par_cnt - p) + (frm_cnt - f) !== 0) begin errors++; $display("FAIL glitch_flags: got %0d want 0", (par_cnt - p) + (frm_cnt - f)); end
        pop_one();
    endtask

    task automatic test_reset_midframe();
        int p, f, o;
        send_bits(mk_frame(8'h33, 1'b0, 1'b1), 5, -1);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(HALF);
        p = par_cnt; f = frm_cnt; o = ovf_cnt;
        send_frame(8'h5A, 1'b0, 1'b1, -1);
        checks++; if ((rx_valid !== 1'b1) || (rx_data !== 8'h5A)) begin errors++; $display("FAIL midreset_data: got v=%b %h want v=1 5a", rx_valid, rx_data); end
        checks++; if ((par_cnt - p) + (frm_cnt - f) + (ovf_cnt - o) !== 0) begin errors++; $display("FAIL midreset_flags: got %0d want 0", (par_cnt - p) + (frm_cnt - f) + (ovf_cnt - o)); end
        pop_one();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midreset_single: got %b want 0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [3];
        exp_q = '{8'h12, 8'h34, 8'h56};
        for (int k = 0; k < 3; k++) begin
            send_frame(exp_q[k], 1'b0, 1'b1, -1);
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if ((rx_valid !== 1'b1) || (rx_data !== exp_q[k])) begin errors++; $display("FAIL b2b_order_%0d: got v=%b %h want v=1 %h", k, rx_valid, rx_data, exp_q[k]); end
            pop_one();
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", rx_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_timeout();
        test_overflow();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal ps2_clk samples required before the filtered clock changes level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: clock cycles without a filtered falling edge before a partial frame is aborted (2 ms at 25 MHz).
REQ-003 SHALL have port clock, input, 1: single clock, 25 MHz nominal; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1: raw, asynchronous PS/2 clock line.
REQ-006 SHALL have port ps2_data, input, 1: raw, asynchronous PS/2 data line.
REQ-007 SHALL have port rx_data, output, 8: FIFO head scan code; valid only while rx_valid=1.
REQ-008 SHALL have port rx_valid, output, 1: FIFO non-empty.
REQ-009 SHALL have port rx_ready, input, 1: consumer accepts the head byte.
REQ-010 SHALL have port parity_err, output, 1: one-cycle pulse when a frame is discarded for bad parity.
REQ-011 SHALL have port frame_err, output, 1: one-cycle pulse on bad stop bit or timeout abort.
REQ-012 SHALL have port overflow, output, 1: one-cycle pulse when a good frame is dropped because the FIFO is full.

Function
REQ-013 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any other use.
REQ-014 SHALL change the filtered clock level only after FILTER_LEN consecutive synchronized samples of the new level; shorter pulses are ignored.
REQ-015 SHALL detect a falling edge in the cycle the filtered clock registers 1->0, and SHALL sample synchronized ps2_data in that same cycle.
REQ-016 SHALL implement FSM states IDLE, DATA, PARITY, STOP; all transitions occur only on a falling edge, except timeout.
REQ-017 IDLE: edge with data=0 -> DATA, bit count cleared; edge with data=1 -> remain IDLE, no flag.
REQ-018 DATA: shift data LSB-first; after the 8th bit -> PARITY.
REQ-019 PARITY: capture parity bit -> STOP.
REQ-020 STOP: always -> IDLE; if stop=0, pulse frame_err; else if XOR of 8 data bits and parity bit is 0, pulse parity_err; else push the byte; frame_err takes priority over parity_err.
REQ-021 SHALL count cycles since the last falling edge while not IDLE; on reaching TIMEOUT_CYCLES, return to IDLE, discard the partial frame and pulse frame_err.
REQ-022 SHALL buffer bytes in a 4-entry FIFO with a 3-bit occupancy count (0..4), pointers wrapping modulo 4.
REQ-023 rx_valid SHALL assert in the cycle after a push into an empty FIFO (one-cycle latency from the stop-bit edge).
REQ-024 SHALL pop when rx_valid=1 and rx_ready=1; rx_data SHALL present the next entry the following cycle; rx_ready while empty SHALL have no effect.
REQ-025 A push when count=4 without a simultaneous pop SHALL drop the new byte, keep the contents unchanged and pulse overflow.
REQ-026 Simultaneous push and pop SHALL leave count unchanged, including at count=4, with no overflow.
REQ-027 Bytes SHALL be delivered in arrival order.

Reset
REQ-028 reset_n=0 sampled on a clock edge SHALL force: FSM=IDLE, bit count=0, timeout counter=0, FIFO empty, rx_valid=0, rx_data=0x00, parity_err=frame_err=overflow=0, synchronizer and filtered clock=1.
REQ-029 Reset mid-frame SHALL discard the partial frame; the first start bit after release SHALL begin a fresh frame.

Verification
REQ-030 Frame 0x1C, parity 0, stop 1, 12.5 kHz PS/2 clock -> rx_valid=1, rx_data=0x1C; one pulse of rx_ready -> rx_valid=0; no error flags.
REQ-031 Frame 0x1C with parity 1 -> one parity_err pulse, rx_valid stays 0; frame 0x1C with stop 0 -> one frame_err pulse only.
REQ-032 Start plus 4 data bits, then line idle for TIMEOUT_CYCLES -> one frame_err pulse, FSM IDLE; next frame 0xF0 received correctly.
REQ-033 rx_ready=0, frames 0x01..0x05 -> overflow pulse on the 5th; drain yields 0x01,0x02,0x03,0x04, then rx_valid=0.
REQ-034 3-cycle low glitch on ps2_clk mid-frame -> no extra bit shifted; frame 0xAA still received correctly.
REQ-035 reset_n=0 for 1 cycle after 5 bits of a frame, then frame 0x5A -> only 0x5A delivered, no error flags.
